// File: rtl/sample_framer_pkg.sv
// sample_framer shared types and constants.
// Word format: {SYNC_BYTE, seq} header, zero-extended payload, optional sum.
package sample_framer_pkg;

  localparam int OUT_W = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TRAILER
  } state_e;

  function automatic logic [OUT_W-1:0] hdr_word(
    input logic [7:0] seq
  );
    return {SYNC_BYTE, seq};
  endfunction

endpackage

// File: rtl/sample_framer_csum.sv
// sample_framer payload checksum: 16-bit wrap-around sum.
// Clear has priority over add.
module sample_framer_csum
  import sample_framer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [OUT_W-1:0] sum_o
);

  logic [OUT_W-1:0] sum_q;
  logic [OUT_W-1:0] sum_d;

  // next sum: clear at frame start, accumulate each captured word
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // accumulator register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sample_framer.sv
// sample_framer: drains the sample FIFO into header/payload/trailer frames.
// Trailer + checksum present only with SAMPLE_FRAMER_CHECKSUM_EN defined.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       frame_cnt
);

  localparam logic [7:0] LEN = 8'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             out_free;
  logic             rd_en;
  logic [OUT_W-1:0] sample_w;

`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  logic             csum_clr;
  logic             csum_add;
  logic [OUT_W-1:0] csum_sum;

  sample_framer_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .data_i (sample_w),
    .sum_o  (csum_sum)
  );
`endif

  // output register may take a new word when empty or being drained
  assign out_free = ~valid_q | out_ready;
  assign sample_w = OUT_W'(fifo_dout);

  // read strobe: capture straight into the output register
  assign rd_en = rst_n
               & (state_q == PAYLOAD)
               & ~fifo_empty
               & out_free
               & (cnt_q < LEN);

  // next-state, output register and counter updates
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
    csum_clr = 1'b0;
    csum_add = 1'b0;
`endif

    if (valid_q & out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (enable & ~fifo_empty) begin
          state_d = HEADER;
        end
      end

      HEADER: begin
        if (out_free) begin
          data_d  = hdr_word(seq_q);
          valid_d = 1'b1;
          last_d  = 1'b0;
          seq_d   = seq_q + 8'd1;
          cnt_d   = '0;
          state_d = PAYLOAD;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
          csum_clr = 1'b1;
`endif
        end
      end

      PAYLOAD: begin
        if (rd_en) begin
          data_d  = sample_w;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
          csum_add = 1'b1;
          last_d   = 1'b0;
          if (cnt_q == LEN - 8'd1) begin
            state_d = TRAILER;
          end
`else
          last_d = (cnt_q == LEN - 8'd1);
`endif
        end
`ifndef SAMPLE_FRAMER_CHECKSUM_EN
        else if (valid_q & last_q & out_ready) begin
          state_d = IDLE;
        end
`endif
      end

      TRAILER: begin
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
        if (last_q) begin
          if (valid_q & out_ready) begin
            state_d = IDLE;
          end
        end else if (out_free) begin
          data_d  = csum_sum;
          valid_d = 1'b1;
          last_d  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      seq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign frame_cnt  = seq_q;

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: randomized frames checked against a frame-level model.
// Builds with or without SAMPLE_FRAMER_CHECKSUM_EN.
module tb_sample_framer;

  localparam int FL = 8;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int WPF = FL + 1 + CS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  logic [13:0] mem [0:16383];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit hold_empty = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;
  assign fifo_dout  = (fifo_rd_en && !fifo_empty) ? mem[rd_ptr[13:0]] : '0;

  sample_framer #(.WIDTH(14), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_cnt  (frame_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall_err = 0;
  int flush_req = 0;
  int flush_ack = 0;
  bit prev_stall = 1'b0;
  bit rd_pend = 1'b0;
  logic [16:0] prev_word;
  logic [16:0] got_q[$];
  int          got_cyc[$];
  logic [16:0] exp_q[$];
  logic [7:0]  exp_seq;

  // stream monitor: handshakes resolve at the next posedge
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        got_cyc.push_back(cyc);
      end
      if (prev_stall && (!out_valid || {out_last, out_data} !== prev_word))
        stall_err++;
      if (out_valid && !out_ready && fifo_rd_en)
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_word = {out_last, out_data};
    end else begin
      prev_stall = 1'b0;
    end
    rd_pend = fifo_rd_en && !fifo_empty;
  end

  // FIFO pop and consumer ready driver
  always @(posedge clk) begin
    #1;
    if (rd_pend) rd_ptr++;
    if (flush_req != flush_ack) begin
      rd_ptr = wr_ptr;
      flush_ack = flush_req;
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] v);
    mem[wr_ptr[13:0]] = v;
    wr_ptr++;
  endtask

  // frame-level model: header, payload words, optional sum trailer
  task automatic add_frame(input logic [7:0] seq, input logic [13:0] s[$]);
    int sum;
    sum = 0;
    exp_q.push_back({1'b0, 8'hA5, seq});
    foreach (s[i]) begin
      exp_q.push_back({(CS == 0) && (i == s.size() - 1), 2'b00, s[i]});
      sum = (sum + int'(s[i])) % 65536;
    end
    if (CS != 0) exp_q.push_back({1'b1, 16'(sum)});
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL wait_words: got %0d words, required %0d", got_q.size(), n);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset out_valid: got %b, required 0", out_valid);
    end
    n_checks++;
    if (out_last !== 1'b0) begin
      n_fail++; $display("FAIL reset out_last: got %b, required 0", out_last);
    end
    n_checks++;
    if (out_data !== 16'h0) begin
      n_fail++; $display("FAIL reset out_data: got %h, required 0000", out_data);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset fifo_rd_en: got %b, required 0", fifo_rd_en);
    end
    n_checks++;
    if (frame_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset frame_cnt: got %h, required 00", frame_cnt);
    end
    rst_n = 1'b1;
    exp_seq = 8'h00;
    tick(1);
    clear_q();
  endtask

  task automatic test_basic();
    logic [13:0] s[$];
    clear_q();
    ready_mode = 0;
    for (int i = 1; i <= FL; i++) s.push_back(14'(i));
    foreach (s[i]) push(s[i]);
    add_frame(exp_seq, s);
    exp_seq++;
    enable = 1'b1;
    wait_words(WPF, 100);
    tick(3);
    enable = 1'b0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL basic length: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_cyc.size() == WPF) begin
      n_checks++;
      if (got_cyc[WPF-1] - got_cyc[0] !== WPF - 1) begin
        n_fail++;
        $display("FAIL basic throughput: got span %0d, required %0d",
                 got_cyc[WPF-1] - got_cyc[0], WPF - 1);
      end
    end
    n_checks++;
    if (frame_cnt !== exp_seq) begin
      n_fail++; $display("FAIL basic frame_cnt: got %h, required %h", frame_cnt, exp_seq);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] s[$];
    clear_q();
    stall_err = 0;
    ready_mode = 1;
    for (int i = 0; i < FL; i++) s.push_back(14'($urandom));
    foreach (s[i]) push(s[i]);
    add_frame(exp_seq, s);
    exp_seq++;
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    wait_words(WPF, 200);
    tick(3);
    ready_mode = 0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL bp length: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_err !== 0) begin
      n_fail++; $display("FAIL bp stall violations: got %0d, required 0", stall_err);
    end
  endtask

  task automatic test_underflow();
    logic [13:0] s[$];
    clear_q();
    ready_mode = 0;
    for (int i = 0; i < FL; i++) s.push_back(14'($urandom));
    for (int i = 0; i < 3; i++) push(s[i]);
    add_frame(exp_seq, s);
    exp_seq++;
    enable = 1'b1;
    wait_words(4, 50);
    tick(5);
    n_checks++;
    if (got_q.size() !== 4) begin
      n_fail++; $display("FAIL uf paused words: got %0d, required 4", got_q.size());
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL uf stalled out_valid: got %b, required 0", out_valid);
    end
    for (int i = 3; i < FL; i++) push(s[i]);
    wait_words(WPF, 100);
    tick(3);
    enable = 1'b0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL uf length: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL uf word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [13:0] s[$];
    bit seen;
    clear_q();
    ready_mode = 0;
    for (int f = 0; f < 256; f++) begin
      s.delete();
      for (int i = 0; i < FL; i++) s.push_back(14'($urandom));
      foreach (s[i]) push(s[i]);
      add_frame(exp_seq, s);
      exp_seq++;
    end
    enable = 1'b1;
    wait_words(256 * WPF, 20000);
    tick(3);
    enable = 1'b0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap length: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    seen = 1'b0;
    for (int f = 0; f + 1 < 256 && (f + 2) * WPF <= got_q.size(); f++)
      if (got_q[f*WPF][7:0] == 8'hFF && got_q[(f+1)*WPF][7:0] == 8'h00)
        seen = 1'b1;
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL wrap seq FF->00: got none, required one");
    end
    if (got_cyc.size() > WPF) begin
      n_checks++;
      if (got_cyc[WPF] - got_cyc[WPF-1] !== 3) begin
        n_fail++;
        $display("FAIL b2b gap: got %0d cycles, required 3",
                 got_cyc[WPF] - got_cyc[WPF-1]);
      end
    end
    n_checks++;
    if (frame_cnt !== exp_seq) begin
      n_fail++; $display("FAIL wrap frame_cnt: got %h, required %h", frame_cnt, exp_seq);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] s[$];
    clear_q();
    ready_mode = 0;
    for (int i = 0; i < FL; i++) push(14'($urandom));
    enable = 1'b1;
    wait_words(4, 50);
    rst_n = 1'b0;
    enable = 1'b0;
    flush_req++;
    tick(2);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst outputs: got v=%b l=%b d=%h, required 0 0 0000",
               out_valid, out_last, out_data);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0 || frame_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst rd_en/frame_cnt: got %b/%h, required 0/00",
               fifo_rd_en, frame_cnt);
    end
    rst_n = 1'b1;
    tick(1);
    clear_q();
    exp_seq = 8'h00;
    for (int i = 0; i < FL; i++) s.push_back(14'($urandom));
    foreach (s[i]) push(s[i]);
    add_frame(exp_seq, s);
    exp_seq++;
    enable = 1'b1;
    wait_words(WPF, 100);
    tick(3);
    enable = 1'b0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst length: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
# sample_framer

Drain stage directly downstream of the 14-bit sample FIFO. It pulls samples with `rd_en` while the FIFO is not empty and wraps each group of FRAME_LEN samples into a frame: a header word with a sync byte and sequence number, the zero-extended payload words, and an optional checksum trailer. Frames leave as 16-bit words on a valid/ready stream toward the link/DMA side.

## Interface
- `WIDTH`, 14, sample width; must be ≤ 16.
- `FRAME_LEN`, 8, samples per frame; range 1..255.
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  allows a new frame to start; sampled only in IDLE.
- `fifo_dout`  in  WIDTH  FIFO read data; valid only in a cycle where `fifo_rd_en` = 1 and `fifo_empty` = 0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  combinational FIFO read strobe.
- `out_data`  out  16  frame word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid` & `out_ready`.
- `out_last`  out  1  marks the final word of a frame.
- `frame_cnt`  out  8  sequence number of the next frame.

## Operation
- States:
  - IDLE → HEADER when `enable` & ~`fifo_empty`.
  - HEADER → PAYLOAD when the header word is loaded.
  - PAYLOAD → TRAILER after FRAME_LEN samples are captured (checksum enabled).
  - PAYLOAD → IDLE instead when checksum is disabled.
  - TRAILER → IDLE when the trailer word is accepted.
- Header word: {8'hA5, `frame_cnt`}. `frame_cnt` increments mod 256 (255 → 0) when the header is loaded.
- Payload word: {(16-WIDTH)'b0, sample}.
- `fifo_rd_en` = (state == PAYLOAD) & ~`fifo_empty` & (~`out_valid` | `out_ready`) & (samples captured < FRAME_LEN).
- A sample is captured into the output register in the same cycle as `fifo_rd_en`. `fifo_dout` is ignored in all other cycles, because the FIFO drives 0 when not read.
- Output register: once `out_valid` = 1, `out_data` and `out_last` hold stable until accepted. No word is dropped or duplicated.
- A FIFO empty mid-frame stalls the frame: `out_valid` drops after the pending word is accepted, and the frame resumes when data returns. There is no timeout.
- Deasserting `enable` mid-frame does not abort; the current frame completes.
- Checksum: 16-bit sum of payload words mod 2^16; header excluded. It clears in HEADER.
- `out_last`: set on the trailer word, or on payload word FRAME_LEN when checksum is disabled.
- Reset (including mid-frame):
  - Frame is aborted; state = IDLE.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0.
  - `frame_cnt` = 0, checksum = 0, sample count = 0.
  - `fifo_rd_en` = 0.

## Timing
- `fifo_empty` falls in cycle N with `enable` = 1 in IDLE → header is `out_valid` at N+2 (N+1 = HEADER load).
- Payload: `fifo_rd_en` in cycle M → word is `out_valid` at M+1.
- With `out_ready` held at 1 and the FIFO non-empty, throughput is one word per cycle with no bubbles between header, payload and trailer.
- Frame length on the stream: FRAME_LEN+2 words (FRAME_LEN+1 without checksum).
- Back-to-back frames: one IDLE cycle between `out_last` acceptance and the next header load.
- Backpressure: while `out_valid` & ~`out_ready`, `fifo_rd_en` = 0 and all state holds.

## Configuration
- `SAMPLE_FRAMER_CHECKSUM_EN` defined: TRAILER state and checksum accumulator are present; frames carry the trailer word.
- Not defined: no TRAILER state and no accumulator; `out_last` is on the last payload word.

## Structure
- Package `sample_framer_pkg`:
  - state enum (IDLE, HEADER, PAYLOAD, TRAILER);
  - `SYNC_BYTE` = 8'hA5;
  - `OUT_W` = 16.
- One sub-module: `sample_framer_csum`, a 16-bit accumulator with clear/add, instantiated only under the macro. FSM and output register stay in the top.

## Test plan
- Reset → `out_valid`, `out_last`, `fifo_rd_en` = 0; `frame_cnt` = 0.
- FIFO preloaded with 8 samples 0x0001..0x0008, `out_ready` = 1, `enable` = 1 → stream A500, 0001..0008, trailer 0x0024 with `out_last`; 10 consecutive valid cycles; `frame_cnt` = 1.
- Same stimulus without the macro → 9 words; `out_last` on 0x0008.
- `out_ready` toggled 1/0 every cycle → identical word sequence; `out_data` stable while stalled; no FIFO read during stall cycles.
- FIFO empty after 3 samples, refilled 5 cycles later → frame pauses then completes with correct checksum; single header.
- 256 frames → header low byte wraps FF → 00.
- `rst_n` low mid-payload → next frame starts with header A500 and checksum counts only new samples.
